// File: rtl/dmem_wait_responder_if.sv
// Load/store request/response bundle between the CPU data port and the wait-state memory responder.
interface dmem_wait_responder_if;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ready_o;
  logic        err_o;
  logic        busy_o;

  modport master (
    output MemRead_i, MemWrite_i, addr_i, data_i,
    input  data_o, ready_o, err_o, busy_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, data_i,
    output data_o, ready_o, err_o, busy_o
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// Word-addressed data memory that answers one load/store at a time after LATENCY wait states,
// signalling completion (and illegal requests) with a one-cycle ready pulse.
module dmem_wait_responder #(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  dmem_wait_responder_if.slave   bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [31:0]        addr_q,  addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rd_q,    rd_d;
  logic               wr_q,    wr_d;
  logic               ready_q, ready_d;
  logic               err_q,   err_d;
  logic [31:0]        mem_q [DEPTH];

  logic               illegal_c;
  logic               mem_we_c;
  logic [IDX_W-1:0]   idx_c;

  // Legality is judged on the latched request, so it is stable for the whole wait period.
  assign illegal_c = (rd_q & wr_q)
                   | (addr_q[1:0] != 2'b00)
                   | (addr_q[31:2] >= 30'(DEPTH));
  assign idx_c     = addr_q[IDX_W+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    mem_we_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.MemRead_i || bus.MemWrite_i) begin
          addr_d  = bus.addr_i;
          wdata_d = bus.data_i;
          rd_d    = bus.MemRead_i;
          wr_d    = bus.MemWrite_i;
          cnt_d   = CNT_W'(LATENCY);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ready_d = 1'b1;
          err_d   = illegal_c;
          if (!illegal_c) begin
            if (rd_q) rdata_d = mem_q[idx_c];
            mem_we_c = wr_q;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage array; reset wipes every word so an aborted store leaves no trace.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (mem_we_c) begin
      mem_q[idx_c] <= wdata_q;
    end
  end

  assign bus.data_o  = rdata_q;
  assign bus.ready_o = ready_q;
  assign bus.err_o   = err_q;
  assign bus.busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Randomized check of dmem_wait_responder (LATENCY=2 and LATENCY=0 instances) against a
// word-array reference model of the load/store rules.
module tb_dmem_wait_responder;

  localparam int unsigned DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        rd, wr;
  logic [31:0] addr, wdata;

  always #5 clk = ~clk;

  dmem_wait_responder_if bus2 ();
  dmem_wait_responder_if bus0 ();

  // Requests are steered to one instance at a time so each has an independent history.
  assign bus2.MemRead_i  = rd & ~sel;
  assign bus2.MemWrite_i = wr & ~sel;
  assign bus2.addr_i     = addr;
  assign bus2.data_i     = wdata;
  assign bus0.MemRead_i  = rd & sel;
  assign bus0.MemWrite_i = wr & sel;
  assign bus0.addr_i     = addr;
  assign bus0.data_i     = wdata;

  dmem_wait_responder #(.DEPTH(DEPTH), .LATENCY(2), .CNT_W(4)) u_dut2 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus2.slave)
  );

  dmem_wait_responder #(.DEPTH(DEPTH), .LATENCY(0), .CNT_W(4)) u_dut0 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus0.slave)
  );

  wire [31:0] obs_data  = sel ? bus0.data_o  : bus2.data_o;
  wire        obs_ready = sel ? bus0.ready_o : bus2.ready_o;
  wire        obs_err   = sel ? bus0.err_o   : bus2.err_o;
  wire        obs_busy  = sel ? bus0.busy_o  : bus2.busy_o;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem_m  [2][DEPTH];
  logic [31:0] dout_m [2];

  function automatic int lat_of(input logic s);
    return s ? 0 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      dout_m[d] = '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_m[d][i] = '0;
    end
  endtask

  // Apply the load/store rules to the model; returns whether the request is illegal.
  task automatic model_access(input logic s, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic ill);
    int unsigned wi;
    wi  = int'(a[31:2]);
    ill = (r && w) || (a[1:0] != 2'b00) || (wi >= DEPTH);
    if (!ill) begin
      if (r) dout_m[s] = mem_m[s][wi];
      if (w) mem_m[s][wi] = d;
    end
  endtask

  task automatic do_txn(input logic s, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    logic ill;
    int   k;
    model_access(s, r, w, a, d, ill);
    @(negedge clk);
    sel = s; rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    check("busy_start", 32'(obs_busy), 32'd1);
    k = 0;
    while (k < 40 && !obs_ready) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", 32'(k), 32'(lat_of(s) + 1));
    check("err", 32'(obs_err), 32'(ill));
    check("data", obs_data, dout_m[s]);
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    check("pulse_width", 32'(obs_ready), 32'd0);
    check("busy_end", 32'(obs_busy), 32'd0);
  endtask

  // Request held through the response: a second, separate transaction must follow.
  task automatic do_held(input logic s, input logic [31:0] a, input logic [31:0] d);
    logic ill;
    int   k, gap;
    model_access(s, 1'b0, 1'b1, a, d, ill);
    @(negedge clk);
    sel = s; rd = 1'b0; wr = 1'b1; addr = a; wdata = d;
    k = 0;
    while (k < 40 && !obs_ready) begin
      @(posedge clk); #1;
      k++;
    end
    check("held_first", 32'(obs_ready), 32'd1);
    gap = 0;
    @(posedge clk); #1;
    while (gap < 40 && !obs_ready) begin
      gap++;
      @(posedge clk); #1;
    end
    check("held_gap", 32'(gap), 32'(lat_of(s) + 2));
    check("held_err", 32'(obs_err), 32'(ill));
    wr = 1'b0;
    @(posedge clk); #1;
    check("held_end", 32'(obs_ready), 32'd0);
    @(posedge clk); #1;
    check("held_idle", 32'(obs_busy), 32'd0);
  endtask

  task automatic rand_txn(input logic s);
    int          cat, op;
    logic [31:0] a;
    logic        r, w;
    cat = int'($urandom_range(0, 9));
    op  = int'($urandom_range(0, 9));
    if (cat == 0)      a = {23'd0, 7'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
    else if (cat == 1) a = 32'($urandom_range(DEPTH, 32'h000F_FFFF)) << 2;
    else               a = {23'd0, 7'($urandom_range(0, 15)), 2'b00};
    r = (op <= 4);
    w = (op == 0) || (op >= 5);
    do_txn(s, r, w, a, $urandom);
  endtask

  initial begin
    sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", bus2.data_o, 32'd0);
    check("rst_ready", 32'(bus2.ready_o), 32'd0);
    check("rst_err", 32'(bus2.err_o), 32'd0);
    check("rst_busy", 32'(bus2.busy_o), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_busy", 32'(bus2.busy_o), 32'd0);
    end

    do_txn(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    do_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    do_txn(1'b1, 1'b1, 1'b0, 32'h0,  32'h0);
    do_txn(1'b0, 1'b1, 1'b0, 32'h13, 32'h0);
    do_txn(1'b0, 1'b0, 1'b1, 32'h200, 32'hCAFE_F00D);
    do_txn(1'b0, 1'b1, 1'b1, 32'h10, 32'h1111_2222);
    do_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);

    // Reset during the wait period must abort the store and suppress ready.
    @(negedge clk);
    sel = 1'b0; wr = 1'b1; addr = 32'h8; wdata = 32'h1234_5678;
    @(posedge clk); #2;
    rst_n = 1'b0;
    wr = 1'b0;
    model_reset();
    #1;
    check("abort_ready", 32'(bus2.ready_o), 32'd0);
    check("abort_busy", 32'(bus2.busy_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    do_txn(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);

    do_held(1'b0, 32'h20, 32'hA5A5_0001);
    do_held(1'b1, 32'h24, 32'h5A5A_0002);
    do_txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);

    for (int i = 0; i < 80; i++) rand_txn(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
